// File: rtl/myproject_mac_pipe_if.sv
// -----------------------------------------------------------------------------
// myproject_mac_pipe_if
// Handshake bundle for myproject_mac_pipe.
//   din0      signed operand            (producer -> MAC)
//   din1      unsigned operand          (producer -> MAC)
//   in_valid  beat present              (producer -> MAC)
//   in_ready  beat accepted             (MAC -> producer)
//   dout      narrowed signed result    (MAC -> consumer)
//   ovf       result was clamped        (MAC -> consumer)
//   out_valid result held               (MAC -> consumer)
//   out_ready consumer accepts          (consumer -> MAC)
// Modports: master = environment side, slave = MAC side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface myproject_mac_pipe_if #(
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 8
);
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  in_valid;
    logic                  in_ready;
    logic [dout_WIDTH-1:0] dout;
    logic                  ovf;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output din0, din1, in_valid, out_ready,
        input  in_ready, dout, ovf, out_valid
    );

    modport slave (
        input  din0, din1, in_valid, out_ready,
        output in_ready, dout, ovf, out_valid
    );
endinterface

// File: rtl/myproject_mac_pipe.sv
// -----------------------------------------------------------------------------
// myproject_mac_pipe
// Pipelined signed x unsigned multiply-accumulate. ACC_LEN consecutive
// accepted beats are multiplied, carried through NUM_STAGE registers and
// summed into one dot product, which is arithmetic-shifted right by SHIFT
// and narrowed to dout_WIDTH bits.
// Ports:
//   ap_clk  rising-edge clock
//   ap_rst  asynchronous active-high reset
//   bus     myproject_mac_pipe_if.slave (din0/din1/in_valid/in_ready in,
//           dout/ovf/out_valid/out_ready out)
// Configuration macro:
//   MYPROJECT_MAC_SAT_EN  defined   -> out-of-range results clamp, ovf flags it
//                         undefined -> results wrap to dout_WIDTH, ovf = 0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module myproject_mac_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 6,
    parameter int ACC_LEN    = 16,
    parameter int ACC_WIDTH  = 18,
    parameter int SHIFT      = 4,
    parameter int dout_WIDTH = 8
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    myproject_mac_pipe_if.slave bus
);
    localparam int PROD_W = din0_WIDTH + din1_WIDTH + 1;
    localparam int CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    if (NUM_STAGE < 1 || ACC_LEN < 1 || ID < 0) begin : g_bad_param
        $error("myproject_mac_pipe (ID %0d): NUM_STAGE and ACC_LEN must be >= 1", ID);
    end

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [ACC_WIDTH-1:0] prod;
    } stage_t;

    // ---------------- handshake ----------------
    logic out_valid_reg;
    logic stall;
    logic advance;
    logic accept;

    // A held, unconsumed result freezes the whole datapath.
    assign stall        = out_valid_reg && !bus.out_ready;
    assign advance      = !stall;
    assign accept       = bus.in_valid && advance;
    assign bus.in_ready = advance;

    // ---------------- beat counter ----------------
    logic [CNT_W-1:0] cnt_reg;
    logic             beat_first;
    logic             beat_last;

    assign beat_first = (cnt_reg == '0);
    assign beat_last  = (cnt_reg == CNT_LAST);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= beat_last ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    // ---------------- multiplier ----------------
    logic signed [din0_WIDTH-1:0] din0_s;
    logic signed [PROD_W-1:0]     op0_ext;
    logic signed [PROD_W-1:0]     op1_ext;
    logic signed [PROD_W-1:0]     product;

    assign din0_s  = bus.din0;
    assign op0_ext = PROD_W'(din0_s);               // sign-extended
    assign op1_ext = PROD_W'({1'b0, bus.din1});     // zero-extended, non-negative
    assign product = op0_ext * op1_ext;

    stage_t stage_in;
    always_comb begin
        stage_in       = '0;
        stage_in.valid = bus.in_valid;
        stage_in.first = beat_first;
        stage_in.last  = beat_last;
        stage_in.prod  = ACC_WIDTH'(product);
    end

    // ---------------- product pipeline ----------------
    stage_t stage_reg [NUM_STAGE];

    genvar gi;
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
        stage_t stage_next;
        if (gi == 0) begin : g_entry
            assign stage_next = stage_in;
        end else begin : g_shift
            assign stage_next = stage_reg[gi-1];
        end

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                stage_reg[gi] <= '0;
            end else if (advance) begin
                stage_reg[gi] <= stage_next;
            end
        end
    end

    // ---------------- accumulator at the pipe head ----------------
    stage_t                      head;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [ACC_WIDTH-1:0] acc_sum;

    assign head = stage_reg[NUM_STAGE-1];
    // A first beat restarts the sum directly, so groups need no clear cycle.
    assign acc_sum = head.first ? $signed(head.prod) : acc_reg + $signed(head.prod);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_reg <= '0;
        end else if (advance && head.valid) begin
            acc_reg <= acc_sum;
        end
    end

    // ---------------- rescale and narrow ----------------
    logic [dout_WIDTH-1:0] narrow;
    logic                  narrow_ovf;

`ifdef MYPROJECT_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        ACC_WIDTH'((64'sd1 <<< (dout_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [ACC_WIDTH-1:0] scaled;
    assign scaled = acc_sum >>> SHIFT;

    always_comb begin
        narrow     = dout_WIDTH'(scaled);
        narrow_ovf = 1'b0;
        if (scaled > OUT_MAX) begin
            narrow     = dout_WIDTH'(OUT_MAX);
            narrow_ovf = 1'b1;
        end else if (scaled < OUT_MIN) begin
            narrow     = dout_WIDTH'(OUT_MIN);
            narrow_ovf = 1'b1;
        end
    end
`else
    assign narrow     = dout_WIDTH'(acc_sum >>> SHIFT);
    assign narrow_ovf = 1'b0;
`endif

    // ---------------- output register ----------------
    logic [dout_WIDTH-1:0] dout_reg;
    logic                  ovf_reg;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
            ovf_reg       <= 1'b0;
        end else if (advance && head.valid && head.last) begin
            // A new result may replace the one being consumed on this edge.
            out_valid_reg <= 1'b1;
            dout_reg      <= narrow;
            ovf_reg       <= narrow_ovf;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.dout      = dout_reg;
    assign bus.ovf       = ovf_reg;
endmodule
